// File: rtl/inst_linebuf_types.sv
// Shared types and helpers for the instruction line buffer.
package inst_linebuf_types;

  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned LINE_W         = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PREFETCH = 2'd2
  } linebuf_state_t;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/inst_line_entry.sv
// One cached instruction line: valid, tag and data with asynchronous clear,
// plus tag compare and word select against the current fetch address.
module inst_line_entry
  import inst_linebuf_types::*;
#(
  parameter int unsigned TAG_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [LINE_W-1:0] i_line,
  input  logic [TAG_W-1:0]  i_addr_tag,
  input  logic [2:0]        i_word_sel,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_hit,
  output logic [31:0]       o_word
);

  logic                                r_valid;
  logic [TAG_W-1:0]                    r_tag;
  logic [WORDS_PER_LINE-1:0][31:0]     r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_line;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_hit   = r_valid && (r_tag == i_addr_tag);
  assign o_word  = r_data[i_word_sel];

endmodule

// File: rtl/inst_line_buffer.sv
// Single-line instruction buffer between fetch and the memory port.
// Define INST_LINE_PREFETCH_EN to add a next-line prefetch entry.
module inst_line_buffer
  import inst_linebuf_types::*;
#(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_read,
  output logic [31:0]       inst_rdata,
  output logic              inst_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned TAG_W = ADDR_W - S_OFFSET;

  linebuf_state_t    r_state, w_state_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [TAG_W-1:0]  w_req_tag;
  logic [2:0]        w_word_sel;
  logic              w_hit;
  logic [31:0]       w_word;
  logic              w_unused;

  assign w_req_tag  = inst_addr[ADDR_W-1:S_OFFSET];
  assign w_word_sel = inst_addr[S_OFFSET-1:2];

`ifdef INST_LINE_PREFETCH_EN

  logic [1:0]             w_load;
  logic [1:0]             w_hit_e;
  logic [1:0]             w_valid_e;
  logic [1:0][TAG_W-1:0]  w_tag_e;
  logic [1:0][31:0]       w_word_e;
  // r_sel names the demand entry; a prefetch hit swaps roles by flipping it.
  logic                   r_sel, w_sel_next;
  logic                   r_pf_pending, w_pf_pending_next;
  logic                   w_dem_hit, w_pf_hit;
  logic [ADDR_W-1:0]      w_next_line;
  logic                   w_pf_has_next;

  inst_line_entry #(.TAG_W(TAG_W)) u_entry0 (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load[0]),
    .i_tag      (r_mem_addr[ADDR_W-1:S_OFFSET]),
    .i_line     (mem_rdata),
    .i_addr_tag (w_req_tag),
    .i_word_sel (w_word_sel),
    .o_valid    (w_valid_e[0]),
    .o_tag      (w_tag_e[0]),
    .o_hit      (w_hit_e[0]),
    .o_word     (w_word_e[0])
  );

  inst_line_entry #(.TAG_W(TAG_W)) u_entry1 (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load[1]),
    .i_tag      (r_mem_addr[ADDR_W-1:S_OFFSET]),
    .i_line     (mem_rdata),
    .i_addr_tag (w_req_tag),
    .i_word_sel (w_word_sel),
    .o_valid    (w_valid_e[1]),
    .o_tag      (w_tag_e[1]),
    .o_hit      (w_hit_e[1]),
    .o_word     (w_word_e[1])
  );

  assign w_next_line   = r_mem_addr + 32'd32;
  assign w_pf_has_next = w_valid_e[~r_sel] && (w_tag_e[~r_sel] == w_next_line[ADDR_W-1:S_OFFSET]);
  assign w_unused      = ^inst_addr[1:0];

  always_comb begin
    w_state_next      = r_state;
    w_mem_addr_next   = r_mem_addr;
    w_sel_next        = r_sel;
    w_pf_pending_next = r_pf_pending;
    w_load            = 2'b00;
    w_dem_hit         = w_hit_e[r_sel];
    // The prefetch entry may be mid-reload outside IDLE, so only trust it there.
    w_pf_hit          = w_hit_e[~r_sel] && (r_state == IDLE);
    w_hit             = inst_read && (w_dem_hit || w_pf_hit);
    w_word            = w_dem_hit ? w_word_e[r_sel] : w_word_e[~r_sel];
    unique case (r_state)
      IDLE: begin
        w_pf_pending_next = 1'b0;
        if (inst_read && !w_dem_hit && w_pf_hit) begin
          w_sel_next      = ~r_sel;
          w_mem_addr_next = line_addr(inst_addr) + 32'd32;
          w_state_next    = PREFETCH;
        end else if (inst_read && !w_dem_hit) begin
          w_mem_addr_next = line_addr(inst_addr);
          w_state_next    = FETCH;
        end else if (r_pf_pending) begin
          w_mem_addr_next = w_next_line;
          w_state_next    = PREFETCH;
        end
      end
      FETCH: begin
        if (mem_resp) begin
          w_load[r_sel]     = 1'b1;
          w_pf_pending_next = !w_pf_has_next;
          w_state_next      = IDLE;
        end
      end
      PREFETCH: begin
        if (mem_resp) begin
          w_load[~r_sel] = 1'b1;
          w_state_next   = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel        <= 1'b0;
      r_pf_pending <= 1'b0;
    end else begin
      r_sel        <= w_sel_next;
      r_pf_pending <= w_pf_pending_next;
    end
  end

`else

  logic              w_load0;
  logic              w_hit0;
  logic              w_valid0;
  logic [TAG_W-1:0]  w_tag0;
  logic [31:0]       w_word0;

  inst_line_entry #(.TAG_W(TAG_W)) u_entry0 (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load0),
    .i_tag      (r_mem_addr[ADDR_W-1:S_OFFSET]),
    .i_line     (mem_rdata),
    .i_addr_tag (w_req_tag),
    .i_word_sel (w_word_sel),
    .o_valid    (w_valid0),
    .o_tag      (w_tag0),
    .o_hit      (w_hit0),
    .o_word     (w_word0)
  );

  assign w_unused = ^{inst_addr[1:0], w_valid0, w_tag0};

  always_comb begin
    w_state_next    = r_state;
    w_mem_addr_next = r_mem_addr;
    w_load0         = 1'b0;
    w_hit           = inst_read && w_hit0;
    w_word          = w_word0;
    unique case (r_state)
      IDLE: begin
        if (inst_read && !w_hit0) begin
          w_mem_addr_next = line_addr(inst_addr);
          w_state_next    = FETCH;
        end
      end
      FETCH: begin
        // Refill is installed, not forwarded; the hit is re-evaluated in IDLE.
        if (mem_resp) begin
          w_load0      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  assign inst_resp  = w_hit;
  assign inst_rdata = w_hit ? w_word : 32'd0;
  assign mem_read   = (r_state != IDLE);
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_inst_line_buffer.sv
// Directed bench for inst_line_buffer (default single-entry build).
module tb_inst_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  inst_addr;
  logic         inst_read;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_line_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .inst_addr  (inst_addr),
    .inst_read  (inst_read),
    .inst_rdata (inst_rdata),
    .inst_resp  (inst_resp),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  // Memory image: line at 0x60 has word k = 0x00000013 + (k << 8).
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
    return ((a - 32'h60) << 16) | (32'(k) << 8) | 32'h13;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(a, k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic probe(input string tag, input logic er, input logic [31:0] ed,
                       input logic emr, input logic [31:0] ema);
    #1;
    chk({tag, " resp"},     {31'b0, inst_resp}, {31'b0, er});
    chk({tag, " rdata"},    inst_rdata,         ed);
    chk({tag, " mem_read"}, {31'b0, mem_read},  {31'b0, emr});
    chk({tag, " mem_addr"}, mem_addr,           ema);
  endtask

  // Called in the first FETCH cycle; answers in the lat-th FETCH cycle.
  task automatic serve(input string tag, input logic [31:0] a, input int lat);
    for (int i = 1; i < lat; i++) begin
      probe({tag, " wait"}, 1'b0, 32'd0, 1'b1, a);
      tick();
    end
    mem_rdata = mem_line(a);
    mem_resp  = 1'b1;
    probe({tag, " resp cyc"}, 1'b0, 32'd0, 1'b1, a);
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h64, 1'b1, 32'h00000113};
    vecs[1] = '{1'b1, 32'h68, 1'b1, 32'h00000213};
    vecs[2] = '{1'b1, 32'h6C, 1'b1, 32'h00000313};
    vecs[3] = '{1'b1, 32'h70, 1'b1, 32'h00000413};
    vecs[4] = '{1'b1, 32'h74, 1'b1, 32'h00000513};
    vecs[5] = '{1'b1, 32'h78, 1'b1, 32'h00000613};
    vecs[6] = '{1'b1, 32'h7C, 1'b1, 32'h00000713};
    vecs[7] = '{1'b0, 32'h64, 1'b0, 32'h00000000};
    vecs[8] = '{1'b1, 32'h61, 1'b1, 32'h00000013};
    vecs[9] = '{1'b1, 32'h7F, 1'b1, 32'h00000713};

    reset     = 1'b1;
    inst_read = 1'b0;
    inst_addr = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    probe("reset", 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    tick();

    // Cold miss with 3-cycle memory.
    inst_read = 1'b1;
    inst_addr = 32'h60;
    probe("cold idle", 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    serve("cold", 32'h60, 3);
    probe("cold hit", 1'b1, 32'h00000013, 1'b0, 32'h60);
    tick();

    // Same-line hits and inst_read=0.
    for (int i = 0; i < 10; i++) begin
      inst_read = vecs[i].rd;
      inst_addr = vecs[i].addr;
      probe($sformatf("vec%0d", i), vecs[i].resp, vecs[i].data, 1'b0, 32'h60);
      tick();
    end

    // Stray memory response while IDLE must not touch the line.
    inst_read = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = '1;
    probe("idle resp", 1'b0, 32'd0, 1'b0, 32'h60);
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    inst_read = 1'b1;
    inst_addr = 32'h60;
    probe("after idle resp", 1'b1, 32'h00000013, 1'b0, 32'h60);
    tick();

    // Redirect during FETCH.
    inst_addr = 32'h100;
    probe("redir idle", 1'b0, 32'd0, 1'b0, 32'h60);
    tick();
    inst_addr = 32'h200;
    serve("redir", 32'h100, 3);
    probe("redir reeval", 1'b0, 32'd0, 1'b0, 32'h100);
    tick();
    serve("redir2", 32'h200, 2);
    probe("redir hit", 1'b1, mem_word(32'h200, 0), 1'b0, 32'h200);
    tick();

    // Reset mid-refill, then a late memory response.
    inst_addr = 32'h100;
    probe("rst miss0", 1'b0, 32'd0, 1'b0, 32'h200);
    tick();
    inst_addr = 32'h200;
    reset     = 1'b1;
    probe("rst async", 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    reset     = 1'b0;
    inst_read = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = mem_line(32'h100);
    probe("rst late resp", 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    inst_read = 1'b1;
    inst_addr = 32'h108;
    probe("rst miss", 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    serve("rst refetch", 32'h100, 1);
    probe("rst hit", 1'b1, mem_word(32'h100, 2), 1'b0, 32'h100);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
